johnson_decoder: RTL
====================

# johnson_decoder

Receive-side companion to the team's 5-bit Johnson (twisted-ring) counter. Samples a Johnson code word, decodes it to a binary index and a one-hot vector, flags illegal codes, and tracks sequence continuity with a lock/unlock state machine. Sits downstream of any Johnson counter to monitor its output and convert it to a binary phase.

## Interface
Parameters:
- N, 5, Johnson register width. Code space is 2N states; index width IW = $clog2(2N), which is 4 at the default.
- LOCK_LEN, 2, consecutive correct advances required to enter LOCKED. Range 1..15.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous active-high reset
- code_in  input  N  Johnson code word
- code_valid  input  1  code_in is sampled this cycle
- idx  output  IW  decoded index 0..2N-1, registered
- onehot  output  2N  one-hot of idx; all zero when the sample is illegal
- idx_valid  output  1  one-cycle pulse per sampled code
- legal  output  1  last sample was a legal Johnson code
- locked  output  1  sequence FSM is in LOCKED
- seq_err  output  1  one-cycle pulse on a loss of lock
- err_cnt  output  8  saturating error count; present only with the macro

## Operation
- Legal code: at most one i in [0, N-2] with code_in[i] != code_in[i+1]. This gives exactly 2N codes.
- Index:
  - code_in[N-1]=0: idx = popcount(code_in).
  - otherwise: idx = 2N − popcount(code_in).
  - Resulting sequence: 00000→0, 00001→1, 00011→2, 00111→3, 01111→4, 11111→5, 11110→6, 11100→7, 11000→8, 10000→9.
- Illegal sample: legal=0, onehot=0, and idx holds its previous value.
- Advance: new idx == (prev+1) mod 2N. The step 2N−1 → 0 is an advance.
- Hold: new idx == prev. A hold is neutral and leaves the run count unchanged.
- FSM states: UNLOCKED and LOCKED. Internal regs: prev_idx, prev_ok flag, run count.
- UNLOCKED:
  - Legal sample with prev_ok and an advance: run+1. When run reaches LOCK_LEN → LOCKED.
  - Legal sample otherwise, excluding a hold: run=0.
  - Every legal sample sets prev_ok=1 and prev_idx=idx.
  - Illegal sample: prev_ok=0, run=0.
- LOCKED:
  - Advance or hold: stay in LOCKED.
  - Illegal sample or any other jump: seq_err=1 for one cycle, → UNLOCKED, run=0. prev_ok and prev_idx update as in UNLOCKED.
- code_valid=0: no state change, idx_valid=0, all other outputs hold.

## Timing
- Latency: 1 cycle. A sample on edge k produces all outputs after edge k, and they are visible during cycle k+1.
- locked rises in the same cycle as the idx_valid of the sample that completes the run. It falls in the same cycle as seq_err.
- Reset values: idx=0, onehot=0, idx_valid=0, legal=0, locked=0, seq_err=0, err_cnt=0. FSM=UNLOCKED, run=0, prev_ok=0.
- rst has priority over code_valid. Reset mid-run discards lock and run progress.

## Configuration
- JOHNSON_DEC_ERRCNT_EN defined:
  - err_cnt port exists.
  - Increments by 1 on each sampled illegal code (in any state) and on each seq_err.
  - A sample that is both illegal and causes seq_err counts once.
  - Saturates at 255 and is cleared only by rst.
- JOHNSON_DEC_ERRCNT_EN undefined: err_cnt port and its logic are absent. All other behaviour is identical.

## Structure
- Package johnson_pkg holds:
  - default N, IW, and 2N localparams;
  - state enum {UNLOCKED, LOCKED};
  - next_idx(idx) wrap function.
- Sub-module johnson_code_decode: purely combinational code_in → {legal, idx}. The top level registers its outputs and owns the FSM and the counter.

## Test plan
- Full cycle: reset, then 20 valid samples of the legal sequence from 00000. idx goes 0..9,0..9. locked=1 from the 2nd advance (3rd sample). No seq_err. err_cnt=0.
- Wrap and hold: lock, feed 10000, 10000, 00000. idx goes 9, 9, 0. locked stays 1.
- Jump: while locked, feed 00111 after 00001 (1→3). seq_err pulses once, locked=0, err_cnt=1. Two further advances re-lock.
- Illegal code: while locked, feed 01010. legal=0, onehot=0, idx unchanged, seq_err=1, err_cnt+1.
- Gaps: interleave code_valid=0 cycles between advances. idx_valid is 0 in gap cycles and lock is unaffected.
- Saturation and reset: 300 illegal samples → err_cnt=255. Assert rst for one cycle mid-stream → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson code decoder.
// Default geometry matches the team's 5-bit Johnson counter.
package johnson_pkg;

  localparam int DEF_N     = 5;
  localparam int DEF_CODES = 2 * DEF_N;
  localparam int DEF_IW    = $clog2(DEF_CODES);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  // Successor of idx in a ring of 'codes' phases (last phase wraps to 0).
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned codes);
    return (idx + 1 >= codes) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code word -> {legal, binary index}.
// No state; the caller registers the results.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code_in,
  output logic          legal,
  output logic [IW-1:0] idx
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] ntrans;
  logic [CW-1:0] pop;

  always_comb begin
    ntrans = '0;
    pop    = '0;
    for (int i = 0; i < N - 1; i++) begin
      ntrans = ntrans + CW'(code_in[i] ^ code_in[i+1]);
    end
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(code_in[i]);
    end
  end

  // A Johnson word is a single run of ones against a run of zeros: at most one edge.
  assign legal = (ntrans < CW'(2));

  // Second half of the ring counts down from 2N; modular arithmetic keeps 2N=2^IW correct.
  assign idx = code_in[N-1] ? (IW'(2 * N) - IW'(pop)) : IW'(pop);

endmodule

// File: rtl/johnson_decoder.sv
// Registered Johnson decoder with sequence lock tracking, 1-cycle latency.
// Optional saturating error counter enabled by JOHNSON_DEC_ERRCNT_EN.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int LOCK_LEN = 2,
  localparam int CODES    = 2 * N,
  localparam int IW       = $clog2(CODES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  output logic [IW-1:0]    idx,
  output logic [CODES-1:0] onehot,
  output logic             idx_valid,
  output logic             legal,
  output logic             locked,
  output logic             seq_err
`ifdef JOHNSON_DEC_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  logic             dec_legal;
  logic [IW-1:0]    dec_idx;

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [CODES-1:0] onehot_q;
  logic             idx_valid_q;
  logic             legal_q;
  logic             seq_err_q;
  logic             prev_ok_q;
  logic [3:0]       run_q;

  logic [IW-1:0]    succ_idx;
  logic             is_adv;
  logic             is_hold;
  logic             lose_lock;

  johnson_code_decode #(
    .N  (N),
    .IW (IW)
  ) u_decode (
    .code_in (code_in),
    .legal   (dec_legal),
    .idx     (dec_idx)
  );

  // idx_q only moves on legal samples, so it doubles as the previous legal index.
  assign succ_idx  = IW'(next_idx(32'(idx_q), CODES));
  assign is_adv    = prev_ok_q && (dec_idx == succ_idx);
  assign is_hold   = prev_ok_q && (dec_idx == idx_q);
  assign lose_lock = code_valid && (state_q == LOCKED) && !(dec_legal && (is_adv || is_hold));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      idx_q       <= '0;
      onehot_q    <= '0;
      idx_valid_q <= 1'b0;
      legal_q     <= 1'b0;
      seq_err_q   <= 1'b0;
      prev_ok_q   <= 1'b0;
      run_q       <= '0;
    end else begin
      idx_valid_q <= code_valid;
      seq_err_q   <= 1'b0;
      if (code_valid) begin
        legal_q   <= dec_legal;
        prev_ok_q <= dec_legal;
        if (dec_legal) begin
          idx_q    <= dec_idx;
          onehot_q <= CODES'(1) << dec_idx;
        end else begin
          onehot_q <= '0;
        end
        case (state_q)
          UNLOCKED: begin
            if (!dec_legal) begin
              run_q <= '0;
            end else if (is_adv) begin
              run_q <= run_q + 4'd1;
              if (run_q + 4'd1 == 4'(LOCK_LEN)) begin
                state_q <= LOCKED;
              end
            end else if (!is_hold) begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            if (lose_lock) begin
              state_q   <= UNLOCKED;
              seq_err_q <= 1'b1;
              run_q     <= '0;
            end
          end
          default: state_q <= UNLOCKED;
        endcase
      end
    end
  end

  assign idx       = idx_q;
  assign onehot    = onehot_q;
  assign idx_valid = idx_valid_q;
  assign legal     = legal_q;
  assign locked    = (state_q == LOCKED);
  assign seq_err   = seq_err_q;

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic       err_hit;

  // An illegal sample that also drops lock is a single event.
  assign err_hit = code_valid && (!dec_legal || lose_lock);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_hit && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
